// File: rtl/exotiny_sim_ctrl.sv
// ---------------------------------------------------------------------------
// exotiny_sim_ctrl
//
// Simulation controller that sits next to exotiny_sim in top-level benches.
// It holds the SoC in reset for RST_CYCLES clocks, then lets it run while
// snooping bus writes:
//   * a write to TOHOST_ADDR with bit 0 set ends the run (value 1 = pass,
//     any other odd value = fail, code in the upper bits);
//   * a write to CONSOLE_ADDR emits one character;
//   * an optional cycle budget ends the run with a timeout.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   restart_i    re-run request, returns to the reset hold phase
//   wr_valid_i   bus write strobe (one cycle per write)
//   wr_addr_i    bus write address
//   wr_data_i    bus write data
//   soc_rst_no   active-low reset to the SoC
//   running_o    high while the SoC is running
//   done_o       high once a result (pass/fail/timeout) is reached
//   pass_o       high on pass
//   timeout_o    high on timeout
//   fail_code_o  wr_data_i[DATA_W-1:1] of the failing tohost write, else 0
//   cycles_o     number of RUN cycles (saturating, frozen once done)
//   char_valid_o one-cycle pulse per console write
//   char_o       last console character
// ---------------------------------------------------------------------------
module exotiny_sim_ctrl #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 32,
    parameter int                RST_CYCLES     = 100,
    parameter int                TIMEOUT_CYCLES = 100000,
    parameter int                CNT_W          = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(32'h0000_1000),
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR   = ADDR_W'(32'h0000_1004)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              restart_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              soc_rst_no,
    output logic              running_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [DATA_W-2:0] fail_code_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              char_valid_o,
    output logic [7:0]        char_o
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic              TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                soc_rst_n_q, soc_rst_n_d;
    logic                running_q, running_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-2:0]   fail_code_q, fail_code_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                char_valid_q, char_valid_d;
    logic [7:0]          char_q, char_d;

    logic tohost_wr;
    logic console_wr;

    assign tohost_wr  = wr_valid_i && (wr_addr_i == TOHOST_ADDR);
    assign console_wr = wr_valid_i && (wr_addr_i == CONSOLE_ADDR);

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        fail_code_d  = fail_code_q;
        cycles_d     = cycles_q;
        char_valid_d = 1'b0;
        char_d       = char_q;

        if (restart_i) begin
            // The console character deliberately survives a restart.
            state_d     = S_HOLD;
            hold_d      = '0;
            fail_code_d = '0;
            cycles_d    = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_RUN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!(&cycles_q)) begin
                        cycles_d = cycles_q + 1'b1;
                    end
                    // A terminating tohost write beats a timeout in the same cycle.
                    if (tohost_wr && wr_data_i[0]) begin
                        if (wr_data_i == DATA_W'(1)) begin
                            state_d = S_PASS;
                        end else begin
                            state_d     = S_FAIL;
                            fail_code_d = wr_data_i[DATA_W-1:1];
                        end
                    end else if (TIMEOUT_EN && (cycles_q == TIMEOUT_LAST)) begin
                        state_d = S_TIMEOUT;
                    end
                end
                default: ; // terminal states are sticky
            endcase

            // SoC reset is released in every state except HOLD.
            if (console_wr && (state_q != S_HOLD)) begin
                char_valid_d = 1'b1;
                char_d       = wr_data_i[7:0];
            end
        end

        // Status flags are registered copies of the next-state decode.
        soc_rst_n_d = (state_d != S_HOLD);
        running_d   = (state_d == S_RUN);
        pass_d      = (state_d == S_PASS);
        timeout_d   = (state_d == S_TIMEOUT);
        done_d      = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_HOLD;
            hold_q       <= '0;
            soc_rst_n_q  <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_code_q  <= '0;
            cycles_q     <= '0;
            char_valid_q <= 1'b0;
            char_q       <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            soc_rst_n_q  <= soc_rst_n_d;
            running_q    <= running_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_code_q  <= fail_code_d;
            cycles_q     <= cycles_d;
            char_valid_q <= char_valid_d;
            char_q       <= char_d;
        end
    end

    assign soc_rst_no   = soc_rst_n_q;
    assign running_o    = running_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign fail_code_o  = fail_code_q;
    assign cycles_o     = cycles_q;
    assign char_valid_o = char_valid_q;
    assign char_o       = char_q;

endmodule

// File: tb/tb_exotiny_sim_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exotiny_sim_ctrl
//
// Two controller instances share clock and reset:
//   u_a : RST_CYCLES=100, default timeout  (sequencing, pass, fail, console,
//         restart, asynchronous reset)
//   u_b : RST_CYCLES=3,   TIMEOUT_CYCLES=20 (timeout and pass-beats-timeout)
// ---------------------------------------------------------------------------
module tb_exotiny_sim_ctrl;

    localparam logic [31:0] TOHOST  = 32'h0000_1000;
    localparam logic [31:0] CONSOLE = 32'h0000_1004;

    logic        clk = 1'b0;
    logic        rst;

    logic        restart_a, wr_valid_a;
    logic [31:0] wr_addr_a, wr_data_a;
    logic        soc_rst_no_a, running_a, done_a, pass_a, timeout_a, char_valid_a;
    logic [30:0] fail_code_a;
    logic [31:0] cycles_a;
    logic [7:0]  char_a;

    logic        restart_b, wr_valid_b;
    logic [31:0] wr_addr_b, wr_data_b;
    logic        soc_rst_no_b, running_b, done_b, pass_b, timeout_b, char_valid_b;
    logic [30:0] fail_code_b;
    logic [31:0] cycles_b;
    logic [7:0]  char_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exotiny_sim_ctrl #(.RST_CYCLES(100)) u_a (
        .clk_i(clk), .rst_i(rst), .restart_i(restart_a),
        .wr_valid_i(wr_valid_a), .wr_addr_i(wr_addr_a), .wr_data_i(wr_data_a),
        .soc_rst_no(soc_rst_no_a), .running_o(running_a), .done_o(done_a),
        .pass_o(pass_a), .timeout_o(timeout_a), .fail_code_o(fail_code_a),
        .cycles_o(cycles_a), .char_valid_o(char_valid_a), .char_o(char_a)
    );

    exotiny_sim_ctrl #(.RST_CYCLES(3), .TIMEOUT_CYCLES(20)) u_b (
        .clk_i(clk), .rst_i(rst), .restart_i(restart_b),
        .wr_valid_i(wr_valid_b), .wr_addr_i(wr_addr_b), .wr_data_i(wr_data_b),
        .soc_rst_no(soc_rst_no_b), .running_o(running_b), .done_o(done_b),
        .pass_o(pass_b), .timeout_o(timeout_b), .fail_code_o(fail_code_b),
        .cycles_o(cycles_b), .char_valid_o(char_valid_b), .char_o(char_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one rising edge; outputs are then stable for sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data);
        wr_valid_a = 1'b1;
        wr_addr_a  = addr;
        wr_data_a  = data;
        step();
        wr_valid_a = 1'b0;
    endtask

    // After a restart edge: soc_rst_no must stay low for 99 more edges and
    // rise on the 100th, together with running_o.
    task automatic hold_a(input string tag);
        int low_cnt;
        low_cnt = 0;
        for (int i = 1; i <= 99; i++) begin
            step();
            if (!soc_rst_no_a) low_cnt++;
        end
        check({tag, "_low_edges"}, low_cnt, 99);
        step();
        check({tag, "_released"}, soc_rst_no_a, 1);
        check({tag, "_running"}, running_a, 1);
    endtask

    initial begin
        int low_cnt;
        rst        = 1'b1;
        restart_a  = 1'b0; wr_valid_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        restart_b  = 1'b0; wr_valid_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_soc_rst_no", soc_rst_no_a, 0);
        check("rst_running", running_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cycles", cycles_a, 0);
        check("rst_char", char_a, 0);

        // Reset release: hold for 100 edges; u_b times out along the way.
        rst = 1'b0;
        low_cnt = 0;
        for (int i = 1; i <= 99; i++) begin
            if (i == 10) begin
                wr_valid_a = 1'b1; wr_addr_a = CONSOLE; wr_data_a = 32'h55;
            end
            step();
            wr_valid_a = 1'b0;
            if (i == 10) check("hold_console_no_pulse", char_valid_a, 0);
            if (!soc_rst_no_a) low_cnt++;
            if (i == 3)  check("b_run_cycles0", {running_b, cycles_b}, {1'b1, 32'd0});
            if (i == 22) check("b_before_timeout", {timeout_b, cycles_b}, {1'b0, 32'd19});
            if (i == 23) check("b_timeout", {timeout_b, done_b, running_b, cycles_b},
                               {1'b1, 1'b1, 1'b0, 32'd20});
            if (i == 30) check("b_timeout_frozen", cycles_b, 20);
        end
        check("hold_low_edges", low_cnt, 99);
        check("hold_running_low", running_a, 0);
        step();
        check("run_soc_rst_no", soc_rst_no_a, 1);
        check("run_running", running_a, 1);
        check("run_cycles0", cycles_a, 0);

        // Pass after 50 RUN cycles
        repeat (50) step();
        check("run_cycles50", cycles_a, 50);
        write_a(TOHOST, 32'h1);
        check("pass_flags", {pass_a, done_a, running_a, timeout_a}, 4'b1100);
        check("pass_cycles", cycles_a, 51);
        repeat (5) step();
        check("pass_cycles_frozen", cycles_a, 51);
        write_a(TOHOST, 32'h3);
        check("pass_sticky", {pass_a, fail_code_a}, {1'b1, 31'd0});

        // Console back-to-back in a terminal state
        write_a(CONSOLE, 32'h48);
        check("con1", {char_valid_a, char_a}, {1'b1, 8'h48});
        write_a(CONSOLE, 32'h69);
        check("con2", {char_valid_a, char_a}, {1'b1, 8'h69});
        step();
        check("con_idle", {char_valid_a, char_a}, {1'b0, 8'h69});

        // Restart from PASS
        restart_a = 1'b1;
        step();
        restart_a = 1'b0;
        check("restart_flags", {done_a, pass_a, soc_rst_no_a, running_a}, 4'b0000);
        check("restart_cycles", cycles_a, 0);
        check("restart_char_kept", char_a, 8'h69);
        hold_a("restart");

        // Even tohost write and other-address write are ignored; odd fails
        write_a(TOHOST, 32'h2);
        check("even_ignored", {running_a, done_a}, 2'b10);
        write_a(32'h2000, 32'h1);
        check("other_addr_ignored", {running_a, done_a}, 2'b10);
        write_a(TOHOST, 32'hB);
        check("fail_flags", {done_a, pass_a, running_a}, 3'b100);
        check("fail_code", fail_code_a, 5);
        write_a(TOHOST, 32'h1);
        check("fail_sticky", {pass_a, fail_code_a}, {1'b0, 31'd5});

        // u_b: pass written in the last cycle before timeout wins
        restart_b = 1'b1;
        step();
        restart_b = 1'b0;
        repeat (3) step();
        check("b2_run", {running_b, cycles_b}, {1'b1, 32'd0});
        repeat (19) step();
        check("b2_cycles19", cycles_b, 19);
        wr_valid_b = 1'b1; wr_addr_b = TOHOST; wr_data_b = 32'h1;
        step();
        wr_valid_b = 1'b0;
        check("b2_pass_wins", {pass_b, timeout_b, done_b}, 3'b101);
        check("b2_cycles", cycles_b, 20);

        // Asynchronous reset in the middle of a run
        restart_a = 1'b1;
        step();
        restart_a = 1'b0;
        hold_a("restart2");
        repeat (5) step();
        check("pre_rst_cycles", cycles_a, 5);
        rst = 1'b1;
        #1;
        check("async_rst_flags", {soc_rst_no_a, running_a, done_a, char_valid_a}, 4'b0000);
        check("async_rst_cycles", cycles_a, 0);
        check("async_rst_char", char_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exotiny_sim_ctrl.md
Name: exotiny_sim_ctrl

Overview:
Parametrised simulation controller for ExoTiny benches; replaces fixed clock-count reset and open-ended runs. Sequences the DUT's active-low reset for a programmable hold time, then snoops the SoC bus for tohost/console writes. Enforces a cycle-count timeout and reports pass, fail code, timeout, cycle count and console characters. Instantiated next to exotiny_sim in every top-level bench.

Parameters:
ADDR_W, 32, snooped write address width
DATA_W, 32, snooped write data width (>=8)
RST_CYCLES, 100, cycles soc_rst_no held low after reset/restart (>=1)
TIMEOUT_CYCLES, 100000, RUN cycles before timeout; 0 disables timeout
CNT_W, 32, cycle counter width
TOHOST_ADDR, 32'h0000_1000, address of test-result register
CONSOLE_ADDR, 32'h0000_1004, address of character output register

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
restart_i  in  1  re-run request; re-enters reset hold
wr_valid_i  in  1  SoC bus write strobe, one cycle per write
wr_addr_i  in  ADDR_W  write address
wr_data_i  in  DATA_W  write data
soc_rst_no  out  1  active-low reset to DUT
running_o  out  1  high in RUN
done_o  out  1  high in PASS/FAIL/TIMEOUT
pass_o  out  1  high in PASS
timeout_o  out  1  high in TIMEOUT
fail_code_o  out  DATA_W-1  wr_data_i[DATA_W-1:1] of failing write; 0 otherwise
cycles_o  out  CNT_W  RUN cycle count
char_valid_o  out  1  one-cycle pulse per console write
char_o  out  8  last console character

Behaviour:
- Reset (rst_i high, async): state HOLD, hold counter 0, soc_rst_no=0, running/done/pass/timeout=0, fail_code_o=0, cycles_o=0, char_valid_o=0, char_o=0. Asserting rst_i mid-run returns everything to these values immediately.
- States: HOLD, RUN, PASS, FAIL, TIMEOUT. All outputs registered.
- HOLD: counter increments per cycle; at counter==RST_CYCLES-1 next state RUN. soc_rst_no low for exactly RST_CYCLES rising edges after rst_i release, then 1 from the RUN-entry edge on.
- RUN: running_o=1; cycles_o increments each RUN cycle, saturating at all-ones.
- tohost write (wr_valid_i, wr_addr_i==TOHOST_ADDR) in RUN, evaluated on write data:
  - data==1 -> PASS next cycle; pass_o=1, done_o=1.
  - data[0]==1, data!=1 -> FAIL next cycle; fail_code_o=data[DATA_W-1:1], done_o=1.
  - data[0]==0 -> ignored, stay RUN.
- Timeout: TIMEOUT_CYCLES!=0 and cycles_o==TIMEOUT_CYCLES-1 in RUN with no terminating tohost write -> TIMEOUT; timeout_o=1, done_o=1. Terminating tohost write in the same cycle wins.
- Terminal states (PASS/FAIL/TIMEOUT): sticky; cycles_o frozen; soc_rst_no stays 1; further tohost writes ignored (first result wins).
- Console: write to CONSOLE_ADDR while soc_rst_no==1 (RUN or terminal) -> char_valid_o=1 next cycle for one cycle, char_o=wr_data_i[7:0]; char_o holds afterwards. Back-to-back writes give back-to-back pulses. Writes in HOLD ignored.
- Writes to any other address ignored.
- restart_i (highest priority after rst_i): in any state -> HOLD next cycle, hold counter 0, soc_rst_no=0, flags/fail_code/cycles cleared; char_o retained. In HOLD, it restarts the hold count.
- Simultaneous tohost and console writes impossible (single bus); no special case.

Test Plan:
- Reset sequencing: RST_CYCLES=100, release rst_i -> soc_rst_no low exactly 100 edges, running_o rises with it, cycles_o=0 on first RUN cycle.
- Pass: after 50 RUN cycles write 32'h1 to 0x1000 -> next cycle pass_o=done_o=1, cycles_o frozen at 51; later write 32'h3 -> no change.
- Fail + ignore: write 32'h2 (even) -> stays RUN; write 32'hB -> FAIL, fail_code_o=5, pass_o=0.
- Timeout: TIMEOUT_CYCLES=20, no writes -> timeout_o=1 after 20th RUN cycle, cycles_o=20; repeat with 32'h1 written on cycle 20 -> PASS, timeout_o=0.
- Console: writes 0x48, 0x69 to 0x1004 on consecutive cycles -> two consecutive char_valid_o pulses, char_o 0x48 then 0x69; write during HOLD -> no pulse.
- Restart/reset mid-op: restart_i in PASS -> done_o=0, soc_rst_no low 100 cycles, char_o kept; rst_i mid-RUN -> all outputs reset asynchronously.
